// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg -- shared types and helpers for the scan_mux block.
//   state_t   : FSM encoding (IDLE, SCAN)
//   sel_width : select-bus width for a channel count, max(1, ceil(log2(n)))
package scan_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Bounded loop keeps this usable as a constant function (CHANNELS <= 256).
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 8; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_mux_select.sv
// scan_mux_select -- combinational WIDTH-bit CHANNELS:1 channel selector.
//   data_in : flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel     : channel index; indices >= CHANNELS give all zeros
//   y       : selected channel
module scan_mux_select #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) y = data_in[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux -- registered channel multiplexer with a manual select register
// and an automatic scan of all channels.
//   clock, reset        : rising-edge clock, async active-high reset
//   data_in             : CHANNELS*WIDTH flattened channel data
//   enable_n            : active-low output enable (high forces out to 0)
//   sel_in, sel_load    : manual select value and its load strobe
//   start, stop         : begin / abort a scan pass
//   out, out_n          : registered selected data and its complement
//   out_valid, out_ch   : per-channel scan strobe, index behind current out
//   busy, done, sel_err : in SCAN, end-of-pass strobe, bad-select strobe
// Build option: define SCAN_MUX_CONTINUOUS_EN to keep scanning (wrap to
// channel 0 after each pass) until stop or reset.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int  WIDTH    = 1,
  parameter int  CHANNELS = 8,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      enable_n,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          out,
  output logic [WIDTH-1:0]          out_n,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      busy,
  output logic                      done,
  output logic                      sel_err
);

  localparam logic [SEL_W:0]   CH_LIM = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS - 1);

  state_t           state;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] sel_data;
  logic             in_range;

  // One selector serves both modes: the scan counter drives it in SCAN,
  // the manual select register otherwise.
  assign idx      = (state == SCAN) ? cnt : sel_reg;
  assign in_range = {1'b0, sel_in} < CH_LIM;

  scan_mux_select #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) u_select (
    .data_in(data_in),
    .sel    (idx),
    .y      (sel_data)
  );

  assign out_n = ~out;
  assign busy  = (state == SCAN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_reg   <= '0;
      cnt       <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
      case (state)
        IDLE: begin
          out    <= enable_n ? '0 : sel_data;
          out_ch <= sel_reg;
          // start wins; a coincident sel_load is dropped silently
          if (start) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (sel_load) begin
            if (in_range) sel_reg <= sel_in;
            else          sel_err <= 1'b1;
          end
        end
        SCAN: begin
          // Abort holds out/out_ch; only the missing strobes matter here.
          if (stop) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            out       <= enable_n ? '0 : sel_data;
            out_ch    <= cnt;
            out_valid <= 1'b1;
            if (cnt == LAST) begin
              done <= 1'b1;
              cnt  <= '0;
`ifdef SCAN_MUX_CONTINUOUS_EN
              state <= SCAN;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

  typedef struct {
    bit          scan;
    int          sel;
    int          cnt;
    logic [3:0]  out;
    int          out_ch;
    bit          valid;
    bit          done;
    bit          err;
    bit          chk;   // out/out_ch are defined this cycle
  } mdl_t;

`ifdef SCAN_MUX_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h8765_4321;
  logic        enable_n = 1'b0;
  logic [2:0]  sel_in = '0;
  logic        sel_load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  logic [3:0] a_out, a_outn, b_out, b_outn, c_out, c_outn;
  logic [2:0] a_ch, b_ch;
  logic [0:0] c_ch;
  logic       a_valid, a_busy, a_done, a_err;
  logic       b_valid, b_busy, b_done, b_err;
  logic       c_valid, c_busy, c_done, c_err;

  int checks = 0;
  int errors = 0;
  mdl_t m [3];
  int   chans [3] = '{8, 6, 1};

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(4), .CHANNELS(8)) dut_a (
    .clock(clk), .reset(rst), .data_in(data), .enable_n(enable_n),
    .sel_in(sel_in), .sel_load(sel_load), .start(start), .stop(stop),
    .out(a_out), .out_n(a_outn), .out_valid(a_valid), .out_ch(a_ch),
    .busy(a_busy), .done(a_done), .sel_err(a_err));

  scan_mux #(.WIDTH(4), .CHANNELS(6)) dut_b (
    .clock(clk), .reset(rst), .data_in(data[23:0]), .enable_n(enable_n),
    .sel_in(sel_in), .sel_load(sel_load), .start(start), .stop(stop),
    .out(b_out), .out_n(b_outn), .out_valid(b_valid), .out_ch(b_ch),
    .busy(b_busy), .done(b_done), .sel_err(b_err));

  scan_mux #(.WIDTH(4), .CHANNELS(1)) dut_c (
    .clock(clk), .reset(rst), .data_in(data[3:0]), .enable_n(enable_n),
    .sel_in(sel_in[0:0]), .sel_load(sel_load), .start(start), .stop(stop),
    .out(c_out), .out_n(c_outn), .out_valid(c_valid), .out_ch(c_ch),
    .busy(c_busy), .done(c_done), .sel_err(c_err));

  logic [3:0] obs_out [3];
  logic [3:0] obs_outn [3];
  logic [2:0] obs_ch [3];
  logic [3:0] obs_flags [3];   // {valid, done, sel_err, busy}
  assign obs_out[0] = a_out;  assign obs_outn[0] = a_outn;  assign obs_ch[0] = a_ch;
  assign obs_out[1] = b_out;  assign obs_outn[1] = b_outn;  assign obs_ch[1] = b_ch;
  assign obs_out[2] = c_out;  assign obs_outn[2] = c_outn;  assign obs_ch[2] = {2'b00, c_ch};
  assign obs_flags[0] = {a_valid, a_done, a_err, a_busy};
  assign obs_flags[1] = {b_valid, b_done, b_err, b_busy};
  assign obs_flags[2] = {c_valid, c_done, c_err, c_busy};

  function automatic logic [3:0] chan(input logic [31:0] d, input int k);
    return d[k*4 +: 4];
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.scan = 0; r.sel = 0; r.cnt = 0; r.out = '0; r.out_ch = 0;
    r.valid = 0; r.done = 0; r.err = 0; r.chk = 1;
    return r;
  endfunction

  // One clock of the behavioural model, stated in terms of the block's rules.
  function automatic mdl_t step(input mdl_t p, input int n, input bit en_n,
                                input int sel, input bit ld, input bit st,
                                input bit sp, input logic [31:0] d);
    mdl_t r = p;
    r.valid = 0; r.done = 0; r.err = 0; r.chk = 1;
    if (!p.scan) begin
      r.out = en_n ? 4'h0 : chan(d, p.sel);
      r.out_ch = p.sel;
      if (st) begin
        r.scan = 1; r.cnt = 0;
      end else if (ld) begin
        if (sel < n) r.sel = sel;
        else r.err = 1;
      end
    end else if (sp) begin
      r.scan = 0; r.cnt = 0; r.chk = 0;
    end else begin
      r.out = en_n ? 4'h0 : chan(d, p.cnt);
      r.out_ch = p.cnt;
      r.valid = 1;
      r.done = (p.cnt == n - 1);
      r.cnt = (p.cnt + 1) % n;
      if (r.done && !CONT) r.scan = 0;
    end
    return r;
  endfunction

  task automatic tick();
    logic [31:0] d;
    logic [2:0] s;
    bit e, l, st, sp;
    d = data; s = sel_in; e = enable_n; l = sel_load; st = start; sp = stop;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = step(m[i], chans[i], e, (i == 2) ? int'(s[0]) : int'(s), l, st, sp, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_out, a_outn, a_ch, a_valid, a_busy, a_done, a_err} !== {4'h0, 4'hF, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_a got out=%h out_n=%h ch=%0d v/b/d/e=%b%b%b%b exp 0/F/0/0000",
               a_out, a_outn, a_ch, a_valid, a_busy, a_done, a_err);
    end
    checks++;
    if ({c_out, c_outn, c_ch, c_valid, c_busy, c_done, c_err} !== {4'h0, 4'hF, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_c got out=%h out_n=%h ch=%0d exp 0/F/0", c_out, c_outn, c_ch);
    end
  endtask

  task automatic test_manual();
    do_reset();
    data = 32'h8765_4321;
    sel_in = 3'd5; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    checks++;
    if ({a_out, a_outn, a_ch} !== {4'd6, 4'h9, 3'd5}) begin
      errors++;
      $display("FAIL manual got out=%0d out_n=%h ch=%0d exp 6/9/5", a_out, a_outn, a_ch);
    end
    enable_n = 1'b1;
    tick();
    checks++;
    if ({a_out, a_outn} !== {4'h0, 4'hF}) begin
      errors++;
      $display("FAIL manual_en got out=%h out_n=%h exp 0/F", a_out, a_outn);
    end
    enable_n = 1'b0;
  endtask

  task automatic test_range();
    do_reset();
    data = 32'h8765_4321;
    sel_in = 3'd2; sel_load = 1'b1;
    tick();
    checks++;
    if (b_err !== 1'b0) begin
      errors++; $display("FAIL range_ok got sel_err=%b exp 0", b_err);
    end
    sel_in = 3'd7;
    tick();
    sel_load = 1'b0;
    checks++;
    if (b_err !== 1'b1) begin
      errors++; $display("FAIL range_err got sel_err=%b exp 1", b_err);
    end
    tick();
    checks++;
    if ({b_err, b_ch, b_out} !== {1'b0, 3'd2, 4'd3}) begin
      errors++;
      $display("FAIL range_hold got err=%b ch=%0d out=%0d exp 0/2/3", b_err, b_ch, b_out);
    end
  endtask

  task automatic test_scan();
    do_reset();
    data = 32'h8765_4321;
    sel_in = 3'd4; sel_load = 1'b1;
    tick();
    sel_load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL scan_busy got %b exp 1", a_busy);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({a_valid, a_out, a_ch, a_done} !== {1'b1, 4'(k + 1), 3'(k), (k == 7)}) begin
        errors++;
        $display("FAIL scan_step%0d got v=%b out=%0d ch=%0d done=%b exp 1/%0d/%0d/%b",
                 k, a_valid, a_out, a_ch, a_done, k + 1, k, k == 7);
      end
      if (k == 0) begin
        checks++;
        if ({c_valid, c_done, c_out} !== {1'b1, 1'b1, 4'd1}) begin
          errors++;
          $display("FAIL single_ch got v=%b done=%b out=%0d exp 1/1/1", c_valid, c_done, c_out);
        end
      end
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL scan_end_busy got %b exp 0", a_busy);
    end
    tick();
    checks++;
    if ({a_valid, a_out, a_ch} !== {1'b0, 4'd5, 3'd4}) begin
      errors++;
      $display("FAIL scan_resume got v=%b out=%0d ch=%0d exp 0/5/4", a_valid, a_out, a_ch);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    data = 32'h8765_4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({a_valid, a_ch, a_done} !== {1'b1, 3'((i - 1) % 8), (i % 8 == 0)}) begin
        errors++;
        $display("FAIL cont_cyc%0d got v=%b ch=%0d done=%b exp 1/%0d/%b",
                 i, a_valid, a_ch, a_done, (i - 1) % 8, i % 8 == 0);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({a_busy, a_valid} !== 2'b00) begin
      errors++; $display("FAIL cont_stop got busy=%b v=%b exp 0/0", a_busy, a_valid);
    end
  endtask

  task automatic test_abort();
    do_reset();
    data = 32'h8765_4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({a_valid, a_ch} !== {1'b1, 3'(k)}) begin
        errors++; $display("FAIL abort_step%0d got v=%b ch=%0d exp 1/%0d", k, a_valid, a_ch, k);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({a_valid, a_done, a_busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_stop got v=%b done=%b busy=%b exp 000", a_valid, a_done, a_busy);
    end
    // Reset during the third scan cycle, away from any clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    #1;
    checks++;
    if ({a_out, a_outn, a_ch, a_valid, a_busy, a_done, a_err} !== {4'h0, 4'hF, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL abort_reset got out=%h out_n=%h ch=%0d v/b/d/e=%b%b%b%b exp 0/F/0/0000",
               a_out, a_outn, a_ch, a_valid, a_busy, a_done, a_err);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    data = 32'h8765_4321;
    start = 1'b1; sel_load = 1'b1; sel_in = 3'd3;
    tick();
    start = 1'b0; sel_load = 1'b0;
    checks++;
    if ({a_busy, a_err} !== 2'b10) begin
      errors++; $display("FAIL prio_start got busy=%b err=%b exp 1/0", a_busy, a_err);
    end
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({a_valid, a_ch} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL prio_norestart got v=%b ch=%0d exp 1/2", a_valid, a_ch);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if ({a_ch, a_out} !== {3'd0, 4'd1}) begin
      errors++; $display("FAIL prio_selreg got ch=%0d out=%0d exp 0/1", a_ch, a_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      data     = $urandom;
      enable_n = ($urandom_range(0, 3) == 0);
      sel_load = ($urandom_range(0, 3) == 0);
      sel_in   = 3'($urandom_range(0, 7));
      start    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 11) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_flags[i] !== {m[i].valid, m[i].done, m[i].err, m[i].scan}) begin
          errors++;
          $display("FAIL rand%0d_flags cyc %0d got %b exp %b", i, cyc, obs_flags[i],
                   {m[i].valid, m[i].done, m[i].err, m[i].scan});
        end
        if (m[i].chk) begin
          checks++;
          if ({obs_out[i], obs_outn[i], obs_ch[i]} !== {m[i].out, ~m[i].out, 3'(m[i].out_ch)}) begin
            errors++;
            $display("FAIL rand%0d_data cyc %0d got out=%h out_n=%h ch=%0d exp %h/%h/%0d",
                     i, cyc, obs_out[i], obs_outn[i], obs_ch[i], m[i].out, ~m[i].out, m[i].out_ch);
          end
        end
      end
    end
    enable_n = 1'b0; sel_load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    test_reset();
    test_manual();
    test_range();
    if (CONT) test_continuous();
    else      test_scan();
    test_abort();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 8: number of input channels, legal range 1..256.
REQ-003 SHALL have derived localparam SEL_W = max(1, ceil(log2(CHANNELS))).
REQ-004 clock  in  1  single clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 data_in  in  CHANNELS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 enable_n  in  1  active-low output enable; when high, sampled data is forced to 0.
REQ-008 sel_in  in  SEL_W  manual channel select value.
REQ-009 sel_load  in  1  loads sel_in into the select register.
REQ-010 start  in  1  begins a scan of all channels.
REQ-011 stop  in  1  aborts a scan in progress.
REQ-012 out  out  WIDTH  registered selected data.
REQ-013 out_n  out  WIDTH  bitwise complement of out.
REQ-014 out_valid  out  1  one-cycle strobe per scanned channel.
REQ-015 out_ch  out  SEL_W  channel index that produced the current out.
REQ-016 busy  out  1  high while in SCAN.
REQ-017 done  out  1  one-cycle end-of-pass strobe.
REQ-018 sel_err  out  1  one-cycle strobe for an out-of-range sel_load.

Function
REQ-019 SHALL implement FSM states IDLE and SCAN.
REQ-020 IDLE: each cycle out <= enable_n ? 0 : channel[sel_reg]; out_ch <= sel_reg; out_valid <= 0; latency 1 cycle from sel_reg or data_in.
REQ-021 IDLE with sel_load and sel_in < CHANNELS: sel_reg <= sel_in.
REQ-022 IDLE with sel_load and sel_in >= CHANNELS: sel_reg unchanged; sel_err = 1 next cycle for exactly one cycle.
REQ-023 IDLE with start: go to SCAN with cnt = 0; start has priority over a simultaneous sel_load, which is ignored without a sel_err pulse.
REQ-024 SCAN, per cycle: out <= enable_n ? 0 : channel[cnt]; out_ch <= cnt; out_valid <= 1; cnt increments by 1.
REQ-025 SCAN, enable_n high: out_valid still asserted; out = 0.
REQ-026 SCAN with cnt = CHANNELS-1: done <= 1, coincident with the last out_valid; end-of-pass action per REQ-033/034.
REQ-027 SCAN with stop: next state IDLE, no out_valid, no done; stop has priority over end-of-pass.
REQ-028 In SCAN: start is ignored; sel_load is ignored and raises no sel_err.
REQ-029 sel_reg SHALL be unaffected by scanning; IDLE output resumes from sel_reg on the cycle after leaving SCAN.
REQ-030 busy SHALL equal (state == SCAN); out_n SHALL equal ~out at all times.
REQ-031 CHANNELS = 1: a scan SHALL be one cycle long, with out_valid and done asserted together.

Reset
REQ-032 Assertion of reset, including mid-scan, SHALL immediately give: state IDLE, sel_reg 0, cnt 0, out 0, out_n all ones, out_ch 0, out_valid 0, busy 0, done 0, sel_err 0.

Configuration
REQ-033 With SCAN_MUX_CONTINUOUS_EN defined: at end of pass, cnt wraps to 0 and the block stays in SCAN; done pulses on every wrap; only stop or reset exits SCAN.
REQ-034 Without SCAN_MUX_CONTINUOUS_EN: at end of pass the block returns to IDLE after a single pass; ports are identical in both builds.

Structure
REQ-035 Package scan_mux_pkg SHALL hold the state enum (IDLE, SCAN) and the select-width function used to derive SEL_W.
REQ-036 Combinational WIDTH-bit CHANNELS:1 selection SHALL live in sub-module scan_mux_select; scan_mux holds all registers and the FSM.

Verification (WIDTH=4, CHANNELS=8, channel k = k+1, unless noted)
REQ-037 Manual: sel_load with sel_in=5 -> one cycle later out=6, out_n=4'h9, out_ch=5; then enable_n=1 -> out=0, out_n=4'hF.
REQ-038 Range: CHANNELS=6, sel_load with sel_in=7 -> sel_err pulses one cycle and sel_reg holds its prior value of 2.
REQ-039 Scan: start -> 8 consecutive out_valid with out=1..8 and out_ch=0..7; done is coincident with out_ch=7; busy falls afterwards; out then shows channel[sel_reg].
REQ-040 Abort: stop on the 4th scan cycle -> out_valid for channels 0..2 only; no done; IDLE next cycle. Also: reset on the 3rd scan cycle -> all outputs at reset values immediately.
REQ-041 Priority: start and sel_load (sel_in=3) in the same cycle -> scan runs, sel_reg stays 0; start during SCAN -> no restart.
REQ-042 With SCAN_MUX_CONTINUOUS_EN: start, run 20 cycles -> out_ch sequence 0..7,0..7,0..3 and done on cycles 8 and 16; stop -> IDLE.
